// File: rtl/counter_bank_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : counter_bank_pkg                                                |
// | Purpose  : Shared encodings for the counter bank: register selects, channel|
// |            modes, CTRL bit positions and a mode-legalising helper.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package counter_bank_pkg;

   // Register addressed by a bus write (reg_sel field)
   typedef enum logic [1:0] {
      REG_LOAD = 2'd0,
      REG_CTRL = 2'd1,
      REG_CMP  = 2'd2,
      REG_FCLR = 2'd3
   } reg_sel_e;

   // Channel operating mode (CTRL[2:1])
   typedef enum logic [1:0] {
      MODE_ONESHOT = 2'b00,
      MODE_RELOAD  = 2'b01,
      MODE_SQUARE  = 2'b10,
      MODE_PWM     = 2'b11
   } mode_e;

   // CTRL register layout
   localparam int CTRL_EN_BIT    = 0;
   localparam int CTRL_MODE_LSB  = 1;
   localparam int CTRL_MODE_MSB  = 2;
   localparam int CTRL_IRQEN_BIT = 3;

   // Without the PWM hardware, a written PWM mode is folded onto auto-reload
   // so the channel never sits in a mode it cannot execute.
   function automatic mode_e legal_mode(input logic [1:0] raw, input logic pwm_built);
      if (!pwm_built && (raw == MODE_PWM))
         return MODE_RELOAD;
      return mode_e'(raw);
   endfunction

endpackage : counter_bank_pkg
`default_nettype wire

// File: rtl/counter_bank_ch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : counter_bank_ch                                                 |
// | Purpose  : One programmable down-counter channel: tick edge detect, count, |
// |            load, ctrl, optional compare, mode output and sticky flag.      |
// | Config   : COUNTER_BANK_PWM_EN builds the compare register and PWM mode.   |
// | Ports    : clk, rst        clock / synchronous active-high reset           |
// |            i_tick          count clock level (rising edge counts)          |
// |            i_wr_load/ctrl/cmp/fclr  decoded one-cycle write strobes        |
// |            i_wdata         bus write data                                  |
// |            o_count         current count                                   |
// |            o_cnt_out       mode output                                     |
// |            o_flag          sticky terminal-count flag                      |
// |            o_irq_req       flag gated by the channel irq enable            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module counter_bank_ch
   import counter_bank_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_tick,
   input  logic             i_wr_load,
   input  logic             i_wr_ctrl,
`ifdef COUNTER_BANK_PWM_EN
   input  logic             i_wr_cmp,
`endif
   input  logic             i_wr_fclr,
   input  logic [31:0]      i_wdata,
   output logic [WIDTH-1:0] o_count,
   output logic             o_cnt_out,
   output logic             o_flag,
   output logic             o_irq_req
);

`ifdef COUNTER_BANK_PWM_EN
   localparam logic PWM_BUILT = 1'b1;
`else
   localparam logic PWM_BUILT = 1'b0;
`endif

   logic             r_tick_q;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] r_load;
   logic             r_en;
   mode_e            r_mode;
   logic             r_irq_en;
   logic             r_flag;
   logic             r_cnt_out;

   logic [WIDTH-1:0] w_wdata_w;
   logic             w_tick_ev;
   logic             w_wr_blk;
   logic             w_dec;
   logic             w_term;
   logic [WIDTH-1:0] w_count_nxt;
   logic             w_cnt_out_nxt;

   assign w_wdata_w = i_wdata[WIDTH-1:0];
   assign w_tick_ev = i_tick & ~r_tick_q;

   // A register write to this channel takes priority over a coincident tick,
   // which is then lost. Flag clears do not touch the count and do not block.
`ifdef COUNTER_BANK_PWM_EN
   logic [WIDTH-1:0] r_cmp;

   assign w_wr_blk = i_wr_load | i_wr_ctrl | i_wr_cmp;

   always_ff @(posedge clk) begin
      if (rst)
         r_cmp <= '0;
      else if (i_wr_cmp)
         r_cmp <= w_wdata_w;
   end
`else
   assign w_wr_blk = i_wr_load | i_wr_ctrl;
`endif

   // count==0 never decrements; with load==0 in a reload mode this keeps the
   // channel parked at zero with no terminal events.
   assign w_dec  = r_en && w_tick_ev && (r_count != '0) && !w_wr_blk;
   assign w_term = w_dec && (r_count == WIDTH'(1));

   always_comb begin
      w_count_nxt = r_count - WIDTH'(1);
      if (w_term)
         w_count_nxt = (r_mode == MODE_ONESHOT) ? '0 : r_load;
   end

   always_comb begin
      w_cnt_out_nxt = r_cnt_out;
      case (r_mode)
         MODE_ONESHOT: begin
            if (i_wr_load)
               w_cnt_out_nxt = 1'b0;
            else if (w_term)
               w_cnt_out_nxt = 1'b1;
         end
         MODE_SQUARE: begin
            // Square output survives a LOAD; only terminal events toggle it.
            if (w_term)
               w_cnt_out_nxt = ~r_cnt_out;
         end
`ifdef COUNTER_BANK_PWM_EN
         MODE_PWM: begin
            w_cnt_out_nxt = (r_count <= r_cmp);
         end
`endif
         default: begin
            // Auto-reload: single-clock pulse on the terminal event.
            w_cnt_out_nxt = w_term;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick_q  <= 1'b0;
         r_count   <= '0;
         r_load    <= '0;
         r_en      <= 1'b0;
         r_mode    <= MODE_ONESHOT;
         r_irq_en  <= 1'b0;
         r_flag    <= 1'b0;
         r_cnt_out <= 1'b0;
      end else begin
         r_tick_q  <= i_tick;
         r_cnt_out <= w_cnt_out_nxt;

         if (i_wr_load) begin
            r_load  <= w_wdata_w;
            r_count <= w_wdata_w;
         end else if (w_dec) begin
            r_count <= w_count_nxt;
         end

         if (i_wr_ctrl) begin
            r_en     <= i_wdata[CTRL_EN_BIT];
            r_mode   <= legal_mode(i_wdata[CTRL_MODE_MSB:CTRL_MODE_LSB], PWM_BUILT);
            r_irq_en <= i_wdata[CTRL_IRQEN_BIT];
         end

         // Set has priority over a simultaneous clear.
         if (w_term)
            r_flag <= 1'b1;
         else if (i_wr_fclr && i_wdata[0])
            r_flag <= 1'b0;
      end
   end

   assign o_count   = r_count;
   assign o_cnt_out = r_cnt_out;
   assign o_flag    = r_flag;
   assign o_irq_req = r_flag & r_irq_en;

endmodule : counter_bank_ch
`default_nettype wire

// File: rtl/counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : counter_bank                                                    |
// | Purpose  : N-channel programmable down-counter/timer bank with one-shot,   |
// |            auto-reload, square (and optional PWM) modes, sticky flags,     |
// |            combined interrupt and registered count readback.               |
// | Config   : COUNTER_BANK_PWM_EN enables PWM mode and COMPARE registers.     |
// | Ports    : clk, rst     clock / synchronous active-high reset              |
// |            i_tick_in    per-channel count clock levels                     |
// |            i_we         bus write strobe                                   |
// |            i_ch_sel     channel addressed by the write                     |
// |            i_reg_sel    0=LOAD 1=CTRL 2=COMPARE 3=FLAG_CLR                 |
// |            i_wdata      write data                                         |
// |            i_rd_ch      readback channel                                   |
// |            o_rdata      registered zero-extended count of i_rd_ch          |
// |            o_cnt_out    per-channel mode outputs                           |
// |            o_flags      sticky terminal-count flags                        |
// |            o_irq        registered OR of enabled flags                     |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module counter_bank
   import counter_bank_pkg::*;
#(
   parameter  int NUM_CH = 4,
   parameter  int WIDTH  = 32,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] i_tick_in,
   input  logic              i_we,
   input  logic [CH_W-1:0]   i_ch_sel,
   input  logic [1:0]        i_reg_sel,
   input  logic [31:0]       i_wdata,
   input  logic [CH_W-1:0]   i_rd_ch,
   output logic [31:0]       o_rdata,
   output logic [NUM_CH-1:0] o_cnt_out,
   output logic [NUM_CH-1:0] o_flags,
   output logic              o_irq
);

   logic [WIDTH-1:0]  w_count [NUM_CH];
   logic [NUM_CH-1:0] w_irq_req;
   logic [31:0]       w_rd_mux;
   logic [31:0]       r_rdata;
   logic              r_irq;

   // Channel selects beyond NUM_CH match no generate index, so such writes
   // are dropped without an explicit range check.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      logic w_hit;
      assign w_hit = i_we && (i_ch_sel == CH_W'(g));

      counter_bank_ch #(
         .WIDTH (WIDTH)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .i_tick    (i_tick_in[g]),
         .i_wr_load (w_hit && (i_reg_sel == REG_LOAD)),
         .i_wr_ctrl (w_hit && (i_reg_sel == REG_CTRL)),
`ifdef COUNTER_BANK_PWM_EN
         .i_wr_cmp  (w_hit && (i_reg_sel == REG_CMP)),
`endif
         .i_wr_fclr (w_hit && (i_reg_sel == REG_FCLR)),
         .i_wdata   (i_wdata),
         .o_count   (w_count[g]),
         .o_cnt_out (o_cnt_out[g]),
         .o_flag    (o_flags[g]),
         .o_irq_req (w_irq_req[g])
      );
   end

   // Out-of-range readback channels fall through to zero.
   always_comb begin
      w_rd_mux = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (i_rd_ch == CH_W'(k))
            w_rd_mux = 32'(w_count[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
         r_irq   <= 1'b0;
      end else begin
         r_rdata <= w_rd_mux;
         r_irq   <= |w_irq_req;
      end
   end

   assign o_rdata = r_rdata;
   assign o_irq   = r_irq;

endmodule : counter_bank
`default_nettype wire

// File: tb/tb_counter_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_counter_bank                                                 |
// | Purpose  : Self-checking bench for counter_bank (3 channels, 16-bit) with  |
// |            directed scenarios and a random phase against a reference model.|
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_counter_bank;
   import counter_bank_pkg::*;

   localparam int NCH = 3;
   localparam int W   = 16;
`ifdef COUNTER_BANK_PWM_EN
   localparam bit PWM_ON = 1'b1;
`else
   localparam bit PWM_ON = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NCH-1:0] tick_in = '0;
   logic           we = 1'b0;
   logic [1:0]     ch_sel = '0;
   logic [1:0]     reg_sel = '0;
   logic [31:0]    wdata = '0;
   logic [1:0]     rd_ch = '0;
   logic [31:0]    o_rdata;
   logic [NCH-1:0] o_cnt_out;
   logic [NCH-1:0] o_flags;
   logic           o_irq;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [W-1:0]   m_count [NCH];
   logic [W-1:0]   m_load  [NCH];
   logic [W-1:0]   m_cmp   [NCH];
   logic [1:0]     m_mode  [NCH];
   logic [NCH-1:0] m_en   = '0;
   logic [NCH-1:0] m_ie   = '0;
   logic [NCH-1:0] m_flag = '0;
   logic [NCH-1:0] m_out  = '0;
   logic [NCH-1:0] m_tq   = '0;
   logic [31:0]    m_rdata = '0;
   logic           m_irq   = 1'b0;

   counter_bank #(
      .NUM_CH (NCH),
      .WIDTH  (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .i_tick_in (tick_in),
      .i_we      (we),
      .i_ch_sel  (ch_sel),
      .i_reg_sel (reg_sel),
      .i_wdata   (wdata),
      .i_rd_ch   (rd_ch),
      .o_rdata   (o_rdata),
      .o_cnt_out (o_cnt_out),
      .o_flags   (o_flags),
      .o_irq     (o_irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_edge();
      logic [31:0] nrd;
      logic        nirq, ev, wr, term, nout;
      nrd  = '0;
      if (int'(rd_ch) < NCH) nrd = 32'(m_count[rd_ch]);
      nirq = |(m_flag & m_ie);
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            m_count[i] = '0; m_load[i] = '0; m_cmp[i] = '0; m_mode[i] = 2'd0;
         end
         m_en = '0; m_ie = '0; m_flag = '0; m_out = '0; m_tq = '0;
         m_rdata = '0; m_irq = 1'b0;
      end else begin
         m_rdata = nrd;
         m_irq   = nirq;
         for (int i = 0; i < NCH; i++) begin
            ev = tick_in[i] & ~m_tq[i];
            m_tq[i] = tick_in[i];
            wr = we && (int'(ch_sel) == i);
            term = 1'b0;
            nout = m_out[i];
            if (PWM_ON && m_mode[i] == 2'd3) nout = (m_count[i] <= m_cmp[i]);
            else if (m_mode[i] == 2'd1 || m_mode[i] == 2'd3) nout = 1'b0;
            if (wr && reg_sel == REG_LOAD) begin
               m_load[i]  = wdata[W-1:0];
               m_count[i] = wdata[W-1:0];
               if (m_mode[i] == 2'd0) nout = 1'b0;
            end else if (wr && reg_sel == REG_CTRL) begin
               m_en[i]   = wdata[0];
               m_mode[i] = wdata[2:1];
               if (!PWM_ON && m_mode[i] == 2'd3) m_mode[i] = 2'd1;
               m_ie[i]   = wdata[3];
            end else if (wr && reg_sel == REG_CMP && PWM_ON) begin
               m_cmp[i] = wdata[W-1:0];
            end else if (m_en[i] && ev && m_count[i] != 0) begin
               if (m_count[i] == 1) begin
                  term = 1'b1;
                  m_flag[i] = 1'b1;
                  m_count[i] = (m_mode[i] == 2'd0) ? '0 : m_load[i];
                  case (m_mode[i])
                     2'd2:    nout = ~m_out[i];
                     2'd3:    if (!PWM_ON) nout = 1'b1;
                     default: nout = 1'b1;
                  endcase
               end else begin
                  m_count[i] = m_count[i] - 1'b1;
               end
            end
            if (wr && reg_sel == REG_FCLR && wdata[0] && !term) m_flag[i] = 1'b0;
            m_out[i] = nout;
         end
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      chk("rdata",   o_rdata,         m_rdata);
      chk("cnt_out", 32'(o_cnt_out),  32'(m_out));
      chk("flags",   32'(o_flags),    32'(m_flag));
      chk("irq",     32'(o_irq),      32'(m_irq));
   endtask

   task automatic wr(input int ch, input logic [1:0] rs, input logic [31:0] d);
      we = 1'b1; ch_sel = 2'(ch); reg_sel = rs; wdata = d;
      cyc();
      we = 1'b0;
   endtask

   task automatic tick(input int ch);
      tick_in[ch] = 1'b1;
      cyc();
      tick_in[ch] = 1'b0;
      cyc();
   endtask

   initial begin
      int pulses;
      logic exp_sq;
      logic [31:0] ar_seq [4];
      ar_seq[0] = 32'd1; ar_seq[1] = 32'd2; ar_seq[2] = 32'd1; ar_seq[3] = 32'd2;

      // Reset state
      rst = 1'b1; cyc(); cyc(); rst = 1'b0; cyc();
      chk("rst_rdata", o_rdata, 32'd0);
      chk("rst_flags", 32'(o_flags), 32'd0);
      chk("rst_irq",   32'(o_irq), 32'd0);

      // Reset mid-count
      rd_ch = 2'd0;
      wr(0, REG_LOAD, 32'd5); wr(0, REG_CTRL, 32'h1);
      tick(0); tick(0);
      chk("mid_count", o_rdata, 32'd3);
      rst = 1'b1; cyc(); rst = 1'b0; cyc();
      chk("midrst_rdata", o_rdata, 32'd0);
      chk("midrst_out",   32'(o_cnt_out), 32'd0);
      chk("midrst_flags", 32'(o_flags), 32'd0);
      chk("midrst_irq",   32'(o_irq), 32'd0);

      // One-shot on ch1
      rd_ch = 2'd1;
      wr(1, REG_LOAD, 32'd3); wr(1, REG_CTRL, 32'h9);
      tick(1); tick(1);
      tick_in[1] = 1'b1; cyc();
      chk("os_out",     32'(o_cnt_out[1]), 32'd1);
      chk("os_flag",    32'(o_flags[1]),   32'd1);
      chk("os_irq_lag", 32'(o_irq),        32'd0);
      tick_in[1] = 1'b0; cyc();
      chk("os_irq",   32'(o_irq), 32'd1);
      chk("os_count", o_rdata,    32'd0);
      tick(1);
      chk("os_hold_count", o_rdata, 32'd0);
      chk("os_hold_out",   32'(o_cnt_out[1]), 32'd1);

      // Auto-reload on ch2
      rd_ch = 2'd2;
      wr(2, REG_LOAD, 32'd2); wr(2, REG_CTRL, 32'h3);
      pulses = 0;
      for (int t = 0; t < 4; t++) begin
         tick_in[2] = 1'b1; cyc(); pulses += int'(o_cnt_out[2]);
         tick_in[2] = 1'b0; cyc(); pulses += int'(o_cnt_out[2]);
         chk("ar_count", o_rdata, ar_seq[t]);
      end
      chk("ar_pulses", 32'(pulses), 32'd2);

      // Square on ch0
      wr(0, REG_LOAD, 32'd1); wr(0, REG_CTRL, 32'h5);
      exp_sq = 1'b0;
      for (int t = 0; t < 3; t++) begin
         tick(0);
         exp_sq = ~exp_sq;
         chk("sq_toggle", 32'(o_cnt_out[0]), 32'(exp_sq));
      end

      // load==0 in auto-reload
      wr(0, REG_FCLR, 32'h1); wr(0, REG_LOAD, 32'd0); wr(0, REG_CTRL, 32'h3);
      pulses = 0;
      for (int t = 0; t < 10; t++) begin
         tick_in[0] = 1'b1; cyc(); pulses += int'(o_cnt_out[0]);
         tick_in[0] = 1'b0; cyc(); pulses += int'(o_cnt_out[0]);
      end
      chk("z_pulses", 32'(pulses), 32'd0);
      chk("z_flag",   32'(o_flags[0]), 32'd0);

      // LOAD and tick edge in the same clock: tick dropped
      rd_ch = 2'd1;
      tick_in[1] = 1'b1; we = 1'b1; ch_sel = 2'd1; reg_sel = REG_LOAD; wdata = 32'd7;
      cyc();
      we = 1'b0; tick_in[1] = 1'b0;
      cyc();
      chk("coll_count", o_rdata, 32'd7);

      // FLAG_CLR and terminal event in the same clock: flag stays set
      wr(1, REG_LOAD, 32'd1);
      tick_in[1] = 1'b1; we = 1'b1; ch_sel = 2'd1; reg_sel = REG_FCLR; wdata = 32'h1;
      cyc();
      we = 1'b0; tick_in[1] = 1'b0;
      chk("setclr_flag", 32'(o_flags[1]), 32'd1);
      cyc();
      wr(1, REG_FCLR, 32'h1);
      chk("clr_flag", 32'(o_flags[1]), 32'd0);

      // Write to a nonexistent channel is ignored
      wr(3, REG_LOAD, 32'd9);
      rd_ch = 2'd3; cyc(); cyc();
      chk("oob_rdata", o_rdata, 32'd0);

      // PWM (or its auto-reload fallback) on ch2
      rd_ch = 2'd2;
      wr(2, REG_LOAD, 32'd4); wr(2, REG_CMP, 32'd1); wr(2, REG_CTRL, 32'h7);
      pulses = 0;
      for (int t = 0; t < 8; t++) begin
         tick_in[2] = 1'b1; cyc(); pulses += int'(o_cnt_out[2]);
         tick_in[2] = 1'b0; cyc(); pulses += int'(o_cnt_out[2]);
      end
      chk("pwm_high_cycles", 32'(pulses), PWM_ON ? 32'd4 : 32'd2);

      // Random phase
      for (int n = 0; n < 600; n++) begin
         rst     = ($urandom_range(0, 199) == 0);
         tick_in = NCH'($urandom);
         rd_ch   = 2'($urandom);
         we      = ($urandom_range(0, 4) == 0);
         ch_sel  = 2'($urandom);
         reg_sel = 2'($urandom);
         if (reg_sel == REG_CTRL)
            wdata = $urandom | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
         else if ($urandom_range(0, 5) == 0)
            wdata = $urandom;
         else
            wdata = 32'($urandom_range(0, 5));
         cyc();
      end
      rst = 1'b0; we = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_counter_bank
`default_nettype wire
